// File: rtl/rx_frame_buffer_pkg.sv
// ----------------------------------------------------------------------------
// rx_frame_buffer_pkg
//   Shared definitions for the ISO14443A receive path:
//   - CRC_A constants and a byte-serial CRC_A update function, also used by
//     the tx CRC generator.
//   - State encoding of the receive frame buffer FSM.
// ----------------------------------------------------------------------------
package rx_frame_buffer_pkg;

   localparam logic [15:0] CRC_A_INIT           = 16'h6363;
   localparam logic [15:0] CRC_A_POLY_REFLECTED = 16'h8408;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_DONE  = 3'd3,
      ST_DROP  = 3'd4
   } rx_frame_buf_state_e;

   // One byte of CRC_A, processed LSB first with the reflected polynomial.
   function automatic logic [15:0] crc_a_update(input logic [15:0] crc,
                                                input logic [7:0]  data);
      logic [15:0] c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_A_POLY_REFLECTED;
         else                c = c >> 1;
      end
      return c;
   endfunction

endpackage

// File: rtl/crc_a_byte.sv
// ----------------------------------------------------------------------------
// crc_a_byte
//   Byte-serial CRC_A register (init 0x6363, no final XOR).
// Ports:
//   clk, rst : clock, asynchronous active-high reset (crc -> 0x6363)
//   clear    : reload the initial value (wins over en)
//   en       : fold data into the running CRC
//   data     : byte to fold in, LSB is the first bit on air
//   crc      : current CRC register value
// ----------------------------------------------------------------------------
module crc_a_byte
   import rx_frame_buffer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [15:0] crc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc <= CRC_A_INIT;
      end else if (clear) begin
         crc <= CRC_A_INIT;
      end else if (en) begin
         crc <= crc_a_update(crc, data);
      end
   end

endmodule

// File: rtl/rx_frame_buffer.sv
// ----------------------------------------------------------------------------
// rx_frame_buffer
//   Assembles one PCD->PICC frame from the rx byte event stream into a byte
//   buffer, runs CRC_A alongside, and holds the result for the protocol layer
//   until it is acknowledged.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   soc, eoc           : start / end of frame pulses from rx
//   data, data_bits    : received byte; data_bits 0 = full, 1..7 = partial
//   data_valid         : data/data_bits valid this cycle
//   sequence_error,
//   parity_error       : rx error pulses
//   frame_valid        : a finished frame is held; frame_* stable while high
//   frame_len          : bytes stored (saturates at MAX_BYTES)
//   frame_last_bits    : valid bits of the last stored byte (0 = whole)
//   frame_crc_ok       : CRC_A residue is zero over a >=3 byte whole-byte frame
//   frame_error        : sequence, parity or overflow error in this frame
//   frame_overflow     : more than MAX_BYTES bytes arrived
//   frame_ack          : consumer releases the held frame
//   rd_addr, rd_data   : random-access readback, rd_data registered (1 cycle)
//   frame_dropped      : 1-cycle pulse when a soc arrives while a frame is held
//
// Handshake: frame_valid rises once a frame ends and stays high with all
// frame_* outputs frozen until frame_ack is seen high on a clock edge while
// frame_valid is high; frame_valid falls on the following cycle.
// ----------------------------------------------------------------------------
module rx_frame_buffer
   import rx_frame_buffer_pkg::*;
#(
   parameter  int MAX_BYTES = 16,
   localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             soc,
   input  logic             eoc,
   input  logic [7:0]       data,
   input  logic [2:0]       data_bits,
   input  logic             data_valid,
   input  logic             sequence_error,
   input  logic             parity_error,
   output logic             frame_valid,
   output logic [LEN_W-1:0] frame_len,
   output logic [2:0]       frame_last_bits,
   output logic             frame_crc_ok,
   output logic             frame_error,
   output logic             frame_overflow,
   input  logic             frame_ack,
   input  logic [LEN_W-1:0] rd_addr,
   output logic [7:0]       rd_data,
   output logic             frame_dropped
);

   localparam int IDX_W = $clog2(MAX_BYTES);

   rx_frame_buf_state_e state, state_n;

   logic [7:0]       mem [MAX_BYTES];
   logic [LEN_W-1:0] count;
   logic [2:0]       last_bits;
   logic             err_flag;
   logic             ovf_flag;
   logic             acked;      // held frame released while still in DROP
   logic             dropped;
   logic [15:0]      crc;

   // Control strobes decoded by the FSM
   logic start;                  // begin a new frame: clear count/flags/crc
   logic wr_full;                // store a full byte and update the CRC
   logic wr_part;                // store a partial last byte, no CRC update
   logic err_set;
   logic ovf_set;
   logic drop_set;
   logic ack_set;
   logic room;
   logic any_err;

   assign room    = (count < LEN_W'(MAX_BYTES));
   assign any_err = sequence_error | parity_error;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      start    = 1'b0;
      wr_full  = 1'b0;
      wr_part  = 1'b0;
      err_set  = 1'b0;
      ovf_set  = 1'b0;
      drop_set = 1'b0;
      ack_set  = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (soc) begin
               start   = 1'b1;
               state_n = ST_RECV;
            end
         end

         ST_RECV: begin
            if (soc) begin
               start   = 1'b1;
               state_n = ST_RECV;
            end else if (any_err) begin
               // Same-cycle data is discarded; a same-cycle eoc still ends
               // the frame immediately.
               err_set = 1'b1;
               state_n = eoc ? ST_DONE : ST_DRAIN;
            end else begin
               if (data_valid) begin
                  if (!room)                ovf_set = 1'b1;
                  else if (data_bits == 3'd0) wr_full = 1'b1;
                  else                      wr_part = 1'b1;
               end
               if (eoc) state_n = ST_DONE;
            end
         end

         ST_DRAIN: begin
            if (soc) begin
               start   = 1'b1;
               state_n = ST_RECV;
            end else begin
               if (any_err) err_set = 1'b1;
               if (eoc)     state_n = ST_DONE;
            end
         end

         ST_DONE: begin
            if (frame_ack) begin
               // Ack wins over a coincident soc: release and start afresh.
               if (soc) begin
                  start   = 1'b1;
                  state_n = ST_RECV;
               end else begin
                  state_n = ST_IDLE;
               end
            end else if (soc) begin
               drop_set = 1'b1;
               state_n  = ST_DROP;
            end
         end

         ST_DROP: begin
            // The incoming frame is discarded; wait for its eoc so its tail
            // is not mistaken for a new frame.
            if (eoc) begin
               state_n = (acked || frame_ack) ? ST_IDLE : ST_DONE;
            end else if (frame_ack && !acked) begin
               ack_set = 1'b1;
            end
         end

         default: state_n = ST_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         last_bits <= 3'd0;
         err_flag  <= 1'b0;
         ovf_flag  <= 1'b0;
         acked     <= 1'b0;
         dropped   <= 1'b0;
      end else begin
         dropped <= drop_set;

         if (start) begin
            count     <= '0;
            last_bits <= 3'd0;
            err_flag  <= 1'b0;
            ovf_flag  <= 1'b0;
         end else begin
            if (wr_full || wr_part) count     <= count + LEN_W'(1);
            if (wr_part)            last_bits <= data_bits;
            if (err_set)            err_flag  <= 1'b1;
            if (ovf_set)            ovf_flag  <= 1'b1;
         end

         if (state_n != ST_DROP) acked <= 1'b0;
         else if (ack_set)       acked <= 1'b1;
      end
   end

   // Buffer storage: contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (wr_full || wr_part) mem[count[IDX_W-1:0]] <= data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            rd_data <= 8'h00;
      else if (rd_addr < LEN_W'(MAX_BYTES)) rd_data <= mem[rd_addr[IDX_W-1:0]];
      else                                rd_data <= 8'h00;
   end

   crc_a_byte u_crc (
      .clk   (clk),
      .rst   (rst),
      .clear (start),
      .en    (wr_full),
      .data  (data),
      .crc   (crc)
   );

   // ------------------------------------------------------------ outputs
   // Frame outputs read as zero whenever no frame is being presented.
   assign frame_valid     = (state == ST_DONE) || ((state == ST_DROP) && !acked);
   assign frame_len       = frame_valid ? count : '0;
   assign frame_last_bits = frame_valid ? last_bits : 3'd0;
   assign frame_error     = frame_valid && (err_flag || ovf_flag);
   assign frame_overflow  = frame_valid && ovf_flag;
   assign frame_crc_ok    = frame_valid && (crc == 16'h0000) &&
                            (count >= LEN_W'(3)) && (last_bits == 3'd0);
   assign frame_dropped   = dropped;

endmodule

// File: doc/rx_frame_buffer.md
Name: rx_frame_buffer

Overview:
- Sits directly downstream of rx.
- Consumes rx's per-byte event stream (soc/eoc/data/data_bits/data_valid/sequence_error/parity_error) and assembles one complete PCD->PICC frame into a byte buffer.
- Computes CRC_A on the fly and presents the finished frame to the protocol layer via a hold-until-acknowledged handshake with random-access readback.

Parameters:
MAX_BYTES, 16, buffer depth in bytes; frames longer than this flag overflow.
LEN_W, $clog2(MAX_BYTES+1), width of the byte-count output (derived, not overridden).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
soc  in  1  start of frame pulse from rx
eoc  in  1  end of frame pulse from rx
data  in  8  received byte, LSB first bit order already resolved by rx
data_bits  in  3  0 = full byte, 1..7 = valid bits in a partial last byte
data_valid  in  1  data/data_bits valid this cycle
sequence_error  in  1  rx sequence error pulse
parity_error  in  1  rx parity error pulse, also possible in the eoc cycle
frame_valid  out  1  frame complete; all frame_* outputs stable while high
frame_len  out  LEN_W  bytes stored, including a partial last byte
frame_last_bits  out  3  data_bits of the last stored byte (0 = whole)
frame_crc_ok  out  1  CRC_A residue == 0x0000 and frame_len >= 3 and frame_last_bits == 0
frame_error  out  1  OR of sequence, parity and overflow errors for this frame
frame_overflow  out  1  more than MAX_BYTES bytes received
frame_ack  in  1  consumer releases frame; honoured only while frame_valid
rd_addr  in  LEN_W  byte index for readback
rd_data  out  8  buffer[rd_addr], registered, 1-cycle latency
frame_dropped  out  1  1-cycle pulse: a soc arrived while a frame was held

Behaviour:
- Reset: state IDLE.
  - All outputs 0; frame_len 0; crc register 0x6363.
  - Buffer contents are don't-care.
  - Asserting rst mid-frame aborts the frame with no frame_valid.
- States: IDLE, RECV, DRAIN, DONE, DROP.
- IDLE:
  - soc -> RECV; clear count, error flags and last_bits; crc <= 0x6363.
  - data_valid/eoc/errors without a preceding soc are ignored.
- RECV:
  - data_valid with data_bits==0:
    - If count < MAX_BYTES: mem[count] <= data, count++, crc <= crc_a_update(crc, data).
    - Otherwise set overflow, discard the byte and stay in RECV.
  - data_valid with data_bits!=0 (rx only issues this together with eoc): store the byte if there is room, set last_bits, no CRC update.
  - sequence_error or parity_error: set the error flag and go to DRAIN.
    - Any data_valid in the same cycle is discarded.
  - eoc (with or without the same-cycle data/error, processed first) -> DONE.
    - frame_valid asserts the next cycle.
  - soc while in RECV restarts the frame as from IDLE.
- DRAIN: ignore data; errors OR into the flags; eoc -> DONE (frame_error=1).
- DONE:
  - frame_* outputs are held and rd_addr/rd_data remain readable.
  - frame_ack -> IDLE; frame_valid deasserts the next cycle.
  - frame_ack together with soc in the same cycle: ack wins, and the new frame starts (-> RECV) with no drop.
  - soc without ack: frame_dropped pulses, -> DROP.
- DROP:
  - The held frame stays valid; incoming bytes are discarded.
  - eoc -> DONE.
  - frame_ack -> IDLE if no eoc is pending; otherwise remain in DROP until eoc, then -> IDLE.
- CRC_A definition:
  - Reflected polynomial 0x8408 (x^16+x^12+x^5+1), init 0x6363, byte-serial LSB first, no final XOR.
  - frame_crc_ok checks residue==0 over data plus both CRC bytes (low byte first).
  - Update logic is combinational on an 8-bit input.
  - The crc register is only written on accepted full bytes.
- frame_len saturates at MAX_BYTES.
- rd_data for rd_addr >= frame_len is don't-care.
- Write and read ports are never required in the same cycle on the same address; write-first is acceptable.

Decomposition:
- ISO14443A_pkg gains:
  - CRC_A_INIT = 16'h6363
  - CRC_A_POLY_REFLECTED = 16'h8408
  - function crc_a_update(crc16, byte), shared with the future tx CRC generator and with benches.
  - typedef enum RxFrameBufState.
- One sub-module, crc_a_byte: clk, rst, clear, en, byte in, 16-bit crc out.
  - Reused by the tx path.
- Buffer is an inferred register array; no separate RAM module.

Test Plan:
- soc, bytes 0x00 0x00 0xA0 0x1E, eoc -> frame_valid=1, frame_len=4, frame_crc_ok=1, frame_error=0; rd_addr 0..3 returns 00 00 A0 1E with 1-cycle latency.
- soc, bytes 0x12 0x34 0x26 0xCF, eoc -> crc_ok=1. The same frame with 0x27 as the third byte -> crc_ok=0, frame_error=0.
- soc, 0x93, then 0x05 with data_bits=3 + eoc in the same cycle -> frame_len=2, frame_last_bits=3, frame_crc_ok=0.
- soc, 0x11, parity_error, 0x22, eoc -> frame_error=1, frame_len=1, only 0x11 stored. Repeat with sequence_error -> same result.
- MAX_BYTES+2 full bytes, then eoc -> frame_overflow=1, frame_len=MAX_BYTES, first MAX_BYTES bytes intact.
- Held frame A:
  - Second soc/bytes/eoc without ack -> frame_dropped pulse once, A contents unchanged.
  - frame_ack coincident with soc -> no drop; new frame captured.
  - rst mid-frame -> all outputs 0, frame_valid never asserts.
